lux_pwm_ctrl: RTL and testbench

//   Multi-channel, light-driven PWM dimmer that sits behind the BH1750 reader.

---
 rtl/lux_pwm_ctrl_if.sv | 8 +
 rtl/lux_pwm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lux_pwm_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lux_pwm_ctrl_if.sv
// Lux sample stream from the BH1750 reader into the PWM dimmer.
interface lux_pwm_ctrl_if;
    logic [15:0] lux_data;
    logic        lux_valid;

    modport master (output lux_data, output lux_valid);
    modport slave  (input  lux_data, input  lux_valid);
endinterface

// File: rtl/lux_pwm_ctrl.sv
// Multi-channel light-driven PWM dimmer: per-channel mode/level targets, slew-limited duty,
// period-latched PWM compare and a stale-sensor fallback from AUTO to MANUAL.
module lux_pwm_ctrl #(
    parameter int CH        = 2,
    parameter int PWM_BITS  = 8,
    parameter int PWM_DIV   = 50,
    parameter int RAMP_DIV  = 5000,
    parameter int LUX_MAX   = 1000,
    parameter int LUX_SHIFT = 2,
    parameter int STALE_CYC = 50_000_000
) (
    input  logic                   sys_clk,
    input  logic                   _rst,
    lux_pwm_ctrl_if.slave          lux,
    input  logic [2*CH-1:0]        mode,
    input  logic [4*CH-1:0]        level,
    output logic [CH-1:0]          pwm,
    output logic [PWM_BITS*CH-1:0] duty,
    output logic                   stale
);
    localparam int PDW = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
    localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int SCW = $clog2(STALE_CYC + 1);
    localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(32'(MAX) / 32'd9);
    localparam logic [15:0]         LUX_SAT = 16'(LUX_MAX);
    localparam logic [1:0] M_OFF = 2'b00, M_MAN = 2'b01, M_AUTO = 2'b10, M_FULL = 2'b11;

    typedef enum logic [1:0] {S_HOLD = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10} ramp_state_t;

    logic [PDW-1:0]      r_pdiv;
    logic [RDW-1:0]      r_rdiv;
    logic [PWM_BITS-1:0] r_cnt;
    logic [15:0]         r_lux;
    logic [SCW-1:0]      r_stale_cnt;
    logic                r_stale;
    logic [CH-1:0]       r_pwm;
    logic [PWM_BITS-1:0] r_duty   [CH];
    logic [PWM_BITS-1:0] r_duty_q [CH];
    ramp_state_t         r_state  [CH];

    logic                w_ptick;
    logic                w_rtick;
    logic [15:0]         w_lux_red;
    logic [PWM_BITS-1:0] w_auto;
    logic [3:0]          w_lvl      [CH];
    logic [PWM_BITS-1:0] w_man      [CH];
    logic [PWM_BITS-1:0] w_target   [CH];
    logic [PWM_BITS-1:0] w_duty_nxt [CH];
    ramp_state_t         w_state_nxt[CH];

    assign w_ptick   = (r_pdiv == PDW'(PWM_DIV - 1));
    assign w_rtick   = (r_rdiv == RDW'(RAMP_DIV - 1));
    assign w_lux_red = r_lux >> LUX_SHIFT;
    assign w_auto    = MAX - ((w_lux_red > 16'(MAX)) ? MAX : w_lux_red[PWM_BITS-1:0]);

    // Prescalers, PWM counter, lux capture and stale watchdog
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            r_pdiv      <= {PDW{1'b0}};
            r_rdiv      <= {RDW{1'b0}};
            r_cnt       <= {PWM_BITS{1'b0}};
            r_lux       <= 16'd0;
            r_stale_cnt <= {SCW{1'b0}};
            r_stale     <= 1'b0;
        end else begin
            r_pdiv <= w_ptick ? {PDW{1'b0}} : r_pdiv + PDW'(1'b1);
            r_rdiv <= w_rtick ? {RDW{1'b0}} : r_rdiv + RDW'(1'b1);
            if (w_ptick) begin
                r_cnt <= r_cnt + PWM_BITS'(1'b1);
            end
            if (lux.lux_valid) begin
                r_lux       <= (lux.lux_data > LUX_SAT) ? LUX_SAT : lux.lux_data;
                r_stale_cnt <= {SCW{1'b0}};
                r_stale     <= 1'b0;
            end else if (r_stale_cnt < SCW'(STALE_CYC)) begin
                r_stale_cnt <= r_stale_cnt + SCW'(1'b1);
                r_stale     <= (r_stale_cnt == SCW'(STALE_CYC - 1));
            end else begin
                r_stale     <= 1'b1;
            end
        end
    end

    // Per-channel duty target from mode, clamped keypad level and lux
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_lvl[i] = (level[4*i +: 4] > 4'd9) ? 4'd9 : level[4*i +: 4];
            w_man[i] = (w_lvl[i] == 4'd9) ? MAX : PWM_BITS'(w_lvl[i] * STEP);
            case (mode[2*i +: 2])
                M_OFF:   w_target[i] = {PWM_BITS{1'b0}};
                M_MAN:   w_target[i] = w_man[i];
                M_AUTO:  w_target[i] = r_stale ? w_man[i] : w_auto;
                M_FULL:  w_target[i] = MAX;
                default: w_target[i] = {PWM_BITS{1'b0}};
            endcase
        end
    end

    // Ramp FSM next-state and duty step; the compare guard keeps a stale direction from overshooting
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            w_duty_nxt[i]  = r_duty[i];
            w_state_nxt[i] = S_HOLD;
            if (mode[2*i +: 2] == M_OFF) begin
                w_duty_nxt[i] = {PWM_BITS{1'b0}};
            end else begin
                case (r_state[i])
                    S_UP: begin
                        if (w_rtick && (r_duty[i] < w_target[i])) begin
                            w_duty_nxt[i] = r_duty[i] + PWM_BITS'(1'b1);
                        end else begin
                            w_duty_nxt[i] = r_duty[i];
                        end
                    end
                    S_DOWN: begin
                        if (w_rtick && (r_duty[i] > w_target[i])) begin
                            w_duty_nxt[i] = r_duty[i] - PWM_BITS'(1'b1);
                        end else begin
                            w_duty_nxt[i] = r_duty[i];
                        end
                    end
                    default: w_duty_nxt[i] = r_duty[i];
                endcase
            end
            if (w_duty_nxt[i] < w_target[i]) begin
                w_state_nxt[i] = S_UP;
            end else if (w_duty_nxt[i] > w_target[i]) begin
                w_state_nxt[i] = S_DOWN;
            end else begin
                w_state_nxt[i] = S_HOLD;
            end
        end
    end

    // Ramp state, duty, period latch and registered PWM compare
    always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst) begin
            r_pwm <= {CH{1'b0}};
            for (int i = 0; i < CH; i++) begin
                r_duty[i]   <= {PWM_BITS{1'b0}};
                r_duty_q[i] <= {PWM_BITS{1'b0}};
                r_state[i]  <= S_HOLD;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                r_duty[i]  <= w_duty_nxt[i];
                r_state[i] <= w_state_nxt[i];
                if (w_ptick && (r_cnt == MAX)) begin
                    r_duty_q[i] <= r_duty[i];
                end
                r_pwm[i] <= (mode[2*i +: 2] == M_OFF) ? 1'b0 :
                            ((r_cnt < r_duty_q[i]) || (r_duty_q[i] == MAX));
            end
        end
    end

    // Flatten per-channel duty onto the output bus
    always_comb begin
        duty = {(PWM_BITS*CH){1'b0}};
        for (int i = 0; i < CH; i++) begin
            duty[PWM_BITS*i +: PWM_BITS] = r_duty[i];
        end
    end

    assign pwm   = r_pwm;
    assign stale = r_stale;
endmodule

// File: tb/tb_lux_pwm_ctrl.sv
// Scoreboarded bench for lux_pwm_ctrl with fast dividers (PWM_DIV=RAMP_DIV=1, STALE_CYC=1000).
module tb_lux_pwm_ctrl;
    logic        sys_clk = 1'b0;
    logic        _rst;
    logic [3:0]  mode;
    logic [7:0]  level;
    logic [1:0]  pwm;
    logic [15:0] duty;
    logic        stale;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        string      tag;
        int         ch;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];

    lux_pwm_ctrl_if lif ();

    lux_pwm_ctrl #(
        .CH(2), .PWM_BITS(8), .PWM_DIV(1), .RAMP_DIV(1),
        .LUX_MAX(1000), .LUX_SHIFT(2), .STALE_CYC(1000)
    ) dut (
        .sys_clk(sys_clk), ._rst(_rst), .lux(lif.slave),
        .mode(mode), .level(level), .pwm(pwm), .duty(duty), .stale(stale)
    );

    wire [7:0] d0 = duty[7:0];
    wire [7:0] d1 = duty[15:8];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input string tag, input int ch, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.ch  = ch;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic send_lux(input logic [15:0] v);
        lif.lux_data  = v;
        lif.lux_valid = 1'b1;
        step();
        lif.lux_valid = 1'b0;
    endtask

    // Wait for both duties to hold still, then retire every pending expectation.
    task automatic settle();
        int same = 0;
        int n = 0;
        logic [7:0] p0 = d0;
        logic [7:0] p1 = d1;
        sb_t e;
        while (same < 4 && n < 2000) begin
            step();
            n++;
            if (d0 == p0 && d1 == p1) same++;
            else same = 0;
            p0 = d0;
            p1 = d1;
        end
        if (same < 4) chk("settle_timeout", 32'd0, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, (e.ch == 0) ? d0 : d1, e.exp);
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm[0]) n++;
        end
    endtask

    initial begin
        int viol;
        int t1;
        int t_lux;
        int nh;
        int guard;
        logic [7:0] prev;

        _rst          = 1'b1;
        mode          = 4'b0000;
        level         = 8'h00;
        lif.lux_data  = 16'd0;
        lif.lux_valid = 1'b0;
        #1 _rst = 1'b0;
        #1;
        chk("rst_pwm", pwm, 2'b00);
        chk("rst_duty", duty, 16'd0);
        chk("rst_stale", stale, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1 _rst = 1'b1;
        step();
        chk("post_rst_duty", duty, 16'd0);

        // ch0 FULL: one count per cycle up to MAX; ch1 MANUAL level 2
        mode  = {2'b01, 2'b11};
        level = {4'd2, 4'd0};
        viol  = 0;
        t1    = -1;
        prev  = d0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (int'(d0) - int'(prev) < 0 || int'(d0) - int'(prev) > 1) viol++;
            if (d0 == 8'd1 && t1 < 0) t1 = cyc;
            prev = d0;
            if (d0 == 8'd255) break;
        end
        chk("full_step_size", viol, 0);
        chk("full_top", d0, 8'd255);
        chk("full_ramp_cycles", cyc - t1, 254);
        repeat (300) step();
        count_high(nh);
        chk("full_pwm_high", nh, 256);

        // MANUAL level 5 and clamped level 12
        mode[1:0]  = 2'b01;
        level[3:0] = 4'd5;
        push("man5_duty", 0, 8'd140);
        push("ch1_man2_duty", 1, 8'd56);
        settle();
        repeat (300) step();
        count_high(nh);
        chk("man5_pwm_high", nh, 140);
        level[3:0] = 4'd12;
        push("man12_clamp", 0, 8'd255);
        settle();

        // AUTO with lux saturation
        mode[1:0]  = 2'b10;
        level[3:0] = 4'd3;
        send_lux(16'd400);
        push("auto_400", 0, 8'd155);
        settle();
        send_lux(16'd2000);
        push("auto_2000_sat", 0, 8'd5);
        settle();
        send_lux(16'd0);
        push("auto_0", 0, 8'd255);
        settle();
        send_lux(16'd400);
        t_lux = cyc;
        push("auto_400_again", 0, 8'd155);
        settle();

        // Stale fallback to MANUAL level 3
        guard = 0;
        while (cyc - t_lux < 995 && guard < 2000) begin step(); guard++; end
        chk("stale_early", stale, 1'b0);
        while (cyc - t_lux < 1002 && guard < 2000) begin step(); guard++; end
        chk("stale_set", stale, 1'b1);
        push("stale_manual_target", 0, 8'd84);
        settle();
        send_lux(16'd400);
        chk("stale_clear", stale, 1'b0);
        push("unstale_auto", 0, 8'd155);
        settle();

        // Ramp up to 100 then OFF: duty and pwm drop the next cycle
        mode[1:0]  = 2'b01;
        level[3:0] = 4'd0;
        push("man0_duty", 0, 8'd0);
        settle();
        mode[1:0] = 2'b11;
        guard = 0;
        while (d0 != 8'd100 && guard < 300) begin step(); guard++; end
        chk("ramp_reach_100", d0, 8'd100);
        mode[1:0] = 2'b00;
        step();
        chk("off_duty", d0, 8'd0);
        chk("off_pwm", pwm[0], 1'b0);

        // Asynchronous reset mid-ramp
        mode[1:0] = 2'b11;
        repeat (60) step();
        chk("pre_rst_duty_nonzero", d0 != 8'd0, 1'b1);
        #3 _rst = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm, 2'b00);
        chk("mid_rst_duty", duty, 16'd0);
        chk("mid_rst_stale", stale, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
